// File: rtl/matmul_host_frontend.sv
// Host-side front end for a matrix multiplier: parses a 5-word header, loads operands A and B,
// kicks the multiplier and streams the result matrix back to the host row by row.
module matmul_host_frontend #(
  parameter int SEQ_BITS      = 14,
  parameter int OPCODE_MATMUL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [31:0] operation_reg [6],
  output logic [31:0] matrixA_out [SEQ_BITS+1][SEQ_BITS+1],
  output logic [31:0] matrixB_out [SEQ_BITS+1][SEQ_BITS+1],
  output logic        mm_reset,
  output logic        mm_enable,
  input  logic        mm_done,
  input  logic [31:0] matrixC_in [SEQ_BITS+1][SEQ_BITS+1],
  output logic        busy,
  output logic        err
);
  localparam int DIM = SEQ_BITS + 1;
  localparam int IW  = $clog2(DIM);

  typedef enum logic [2:0] {HDR, LOAD_A, LOAD_B, CLR, START, WAIT, STREAM} state_t;

  state_t        state;
  logic [2:0]    hdr_cnt;
  logic [7:0]    row;
  logic [7:0]    col;
  logic          seen_low;
  logic [7:0]    dim_n;
  logic [7:0]    dim_m;
  logic [7:0]    dim_p;
  logic [7:0]    row_lim;
  logic [7:0]    col_lim;
  logic          last_elem;
  logic          accept;
  logic          step;
  logic          hdr_ok;
  logic [IW-1:0] ri;
  logic [IW-1:0] ci;

  function automatic logic in_range(input logic [31:0] v);
    return (v >= 32'd1) && (v <= 32'(DIM));
  endfunction

  assign dim_n = operation_reg[1][7:0];
  assign dim_m = operation_reg[2][7:0];
  assign dim_p = operation_reg[4][7:0];
  assign ri    = row[IW-1:0];
  assign ci    = col[IW-1:0];

  // One row/column walker serves A (N x M), B (M x P) and the result stream (N x P).
  assign row_lim   = (state == LOAD_B) ? dim_m : dim_n;
  assign col_lim   = (state == LOAD_A) ? dim_m : dim_p;
  assign last_elem = (row == row_lim - 8'd1) && (col == col_lim - 8'd1);

  assign in_ready  = !reset && (state == HDR || state == LOAD_A || state == LOAD_B);
  assign accept    = in_valid && in_ready;
  assign out_valid = !reset && (state == STREAM);
  assign out_last  = out_valid && last_elem;
  assign out_data  = matrixC_in[ri][ci];
  assign mm_reset  = reset || (state == CLR);
  assign mm_enable = !reset && (state == START);
  assign busy      = !reset && !(state == HDR && hdr_cnt == 3'd0);
  assign step      = ((state == LOAD_A || state == LOAD_B) && accept) || (out_valid && out_ready);

  // P arrives with the final header word, so it is checked straight off the bus.
  assign hdr_ok = (operation_reg[0] == 32'(OPCODE_MATMUL)) && in_range(operation_reg[1]) &&
                  in_range(operation_reg[2]) && in_range(in_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HDR;
      hdr_cnt  <= '0;
      row      <= '0;
      col      <= '0;
      seen_low <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < 6; i++) operation_reg[i] <= '0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          matrixA_out[i][j] <= '0;
          matrixB_out[i][j] <= '0;
        end
      end
    end else begin
      err <= 1'b0;
      if (step) begin
        if (col == col_lim - 8'd1) begin
          col <= '0;
          row <= (row == row_lim - 8'd1) ? 8'd0 : row + 8'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
      case (state)
        HDR: begin
          if (accept) begin
            operation_reg[hdr_cnt] <= in_data;
            if (hdr_cnt == 3'd4) begin
              hdr_cnt <= '0;
              if (hdr_ok) state <= LOAD_A;
              else err <= 1'b1;
            end else begin
              hdr_cnt <= hdr_cnt + 3'd1;
            end
          end
        end
        LOAD_A: begin
          if (accept) matrixA_out[ri][ci] <= in_data;
          if (step && last_elem) state <= LOAD_B;
        end
        LOAD_B: begin
          if (accept) matrixB_out[ri][ci] <= in_data;
          if (step && last_elem) state <= CLR;
        end
        CLR: state <= START;
        START: begin
          operation_reg[5] <= 32'd1;
          seen_low         <= 1'b0;
          state            <= WAIT;
        end
        // A done flag left high by the previous job is ignored until a low level is seen.
        WAIT: begin
          if (!mm_done) seen_low <= 1'b1;
          else if (seen_low) state <= STREAM;
        end
        STREAM: begin
          if (step && last_elem) begin
            operation_reg[5] <= 32'd0;
            state            <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_host_frontend.sv
// Table-driven bench for matmul_host_frontend with a small behavioural multiplier that accumulates
// into C until cleared by mm_reset, so a missing clear shows up as doubled results.
module tb_matmul_host_frontend;
  localparam int DIM = 15;
  localparam logic [31:0] Z = 32'd0;

  typedef struct packed {
    logic [0:20][31:0] words;
    int                nw;
    logic [0:14][31:0] exp;
    int                ne;
    bit                experr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inData = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] outData;
  logic        outLast;
  logic [31:0] operationReg [6];
  logic [31:0] matA [DIM][DIM];
  logic [31:0] matB [DIM][DIM];
  logic [31:0] matC [DIM][DIM];
  logic        mmReset;
  logic        mmEnable;
  logic        mmDone = 1'b1;
  logic        busy;
  logic        err;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int nMmReset = 0;
  int nEnable = 0;
  int nErr = 0;
  int tMmReset = 0;
  int tEnable = 0;
  int op5Seen = 0;
  int readyMode = 0;
  int readyPhase = 0;
  int mCnt = 0;
  logic        holding = 1'b0;
  logic [31:0] heldData = '0;
  logic [31:0] gotData [$];
  logic        gotLast [$];
  vec_t        vecs [10];

  always #5 clk = ~clk;

  matmul_host_frontend dut (
    .clk(clk), .reset(reset),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_last(outLast),
    .operation_reg(operationReg), .matrixA_out(matA), .matrixB_out(matB),
    .mm_reset(mmReset), .mm_enable(mmEnable), .mm_done(mmDone), .matrixC_in(matC),
    .busy(busy), .err(err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dot(input int r, input int c);
    logic [31:0] s;
    int m;
    s = '0;
    m = int'(operationReg[2]);
    if (m > DIM) m = DIM;
    for (int k = 0; k < m; k++) s += matA[r][k] * matB[k][c];
    return s;
  endfunction

  // Multiplier model: done drops two cycles after enable and rises with the accumulated product.
  always @(posedge clk) begin
    if (mmReset) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) matC[r][c] <= '0;
      mCnt <= 0;
    end else if (mmEnable) begin
      mCnt <= 1;
    end else if (mCnt != 0) begin
      if (mCnt == 2) mmDone <= 1'b0;
      if (mCnt == 4) begin
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++) matC[r][c] <= matC[r][c] + dot(r, c);
        mmDone <= 1'b1;
        mCnt   <= 0;
      end else begin
        mCnt <= mCnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (readyMode == 1) begin
      outReady = (readyPhase % 3 == 0);
      readyPhase++;
    end else begin
      outReady = 1'b1;
    end
  end

  // Sampled mid-cycle: event counters, accepted output words and stall stability.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (mmReset) begin nMmReset++; tMmReset = cyc; end
      if (mmEnable) begin nEnable++; tEnable = cyc; end
      if (err) nErr++;
      if (operationReg[5] != 0) op5Seen = 1;
    end
    if (outValid && outReady) begin
      gotData.push_back(outData);
      gotLast.push_back(outLast);
    end
    if (holding && outValid) checkOutput("stall_hold", outData, heldData);
    holding  = outValid && !outReady;
    heldData = outData;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendWord(input logic [31:0] d);
    int t;
    inValid = 1'b1;
    inData  = d;
    t = 0;
    @(negedge clk);
    while (!inReady && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("send_ready", inReady, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic waitOutputs(input int n, input string name);
    int t;
    t = 0;
    while (gotData.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    checkOutput({name, "_count"}, gotData.size(), n);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    @(posedge clk);
    #1;
    nMmReset = 0; nEnable = 0; nErr = 0; op5Seen = 0;
    gotData.delete();
    gotLast.delete();
    for (int i = 0; i < v.nw; i++) sendWord(v.words[i]);
    if (v.experr) begin
      repeat (3) @(negedge clk);
      checkOutput({name, "_err_pulse"}, nErr, 1);
      checkOutput({name, "_no_enable"}, nEnable, 0);
      checkOutput({name, "_op5"}, op5Seen, 0);
      checkOutput({name, "_busy"}, busy, 0);
    end else begin
      waitOutputs(v.ne, name);
      for (int i = 0; i < v.ne; i++) begin
        checkOutput({name, "_data"}, (i < gotData.size()) ? gotData[i] : 32'hDEADBEEF, v.exp[i]);
        checkOutput({name, "_last"}, (i < gotLast.size()) ? 32'(gotLast[i]) : 32'd7, 32'(i == v.ne - 1));
      end
      checkOutput({name, "_mm_reset_cycles"}, nMmReset, 1);
      checkOutput({name, "_enable_cycles"}, nEnable, 1);
      checkOutput({name, "_enable_after_clr"}, tEnable - tMmReset, 1);
      checkOutput({name, "_op5_seen"}, op5Seen, 1);
      checkOutput({name, "_op5_cleared"}, operationReg[5], 0);
      checkOutput({name, "_busy_idle"}, busy, 0);
    end
  endtask

  initial begin
    logic [31:0] orAll;
    vec_t pv;

    vecs[0] = '{words: {32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd1, 32'd2, 32'd3, 32'd4,
                        32'd5, 32'd6, 32'd7, 32'd8, {8{Z}}}, nw: 13,
                exp: {32'd19, 32'd22, 32'd43, 32'd50, {11{Z}}}, ne: 4, experr: 1'b0};
    vecs[1] = vecs[0];
    vecs[2] = '{words: {32'd2, 32'd2, 32'd2, 32'd2, 32'd2, {16{Z}}}, nw: 5,
                exp: {15{Z}}, ne: 0, experr: 1'b1};
    vecs[3] = '{words: {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd3, 32'd7, {14{Z}}}, nw: 7,
                exp: {32'd21, {14{Z}}}, ne: 1, experr: 1'b0};
    vecs[4] = '{words: {32'd1, 32'd16, 32'd2, 32'd2, 32'd2, {16{Z}}}, nw: 5,
                exp: {15{Z}}, ne: 0, experr: 1'b1};
    vecs[5] = '{words: {32'd1, 32'd2, 32'd0, 32'd2, 32'd2, {16{Z}}}, nw: 5,
                exp: {15{Z}}, ne: 0, experr: 1'b1};
    vecs[6] = '{words: {32'd3, 32'd1, 32'd1, 32'd1, 32'd1, {16{Z}}}, nw: 5,
                exp: {15{Z}}, ne: 0, experr: 1'b1};
    vecs[7] = '{words: {32'd1, 32'd1, 32'd1, 32'd1, 32'd16, {16{Z}}}, nw: 5,
                exp: {15{Z}}, ne: 0, experr: 1'b1};
    vecs[8] = '{words: {32'd1, 32'd3, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
                        {11{Z}}}, nw: 10,
                exp: {32'd10, 32'd12, 32'd15, 32'd18, 32'd20, 32'd24, {9{Z}}}, ne: 6, experr: 1'b0};
    vecs[9] = '{words: {32'd1, 32'd2, 32'd3, 32'd3, 32'd2, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5,
                        32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, {4{Z}}}, nw: 17,
                exp: {32'd58, 32'd64, 32'd139, 32'd154, {11{Z}}}, ne: 4, experr: 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", inReady, 0);
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_out_last", outLast, 0);
    checkOutput("rst_mm_enable", mmEnable, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mm_reset", mmReset, 1);
    orAll = '0;
    for (int i = 0; i < 6; i++) orAll |= operationReg[i];
    checkOutput("rst_operation_reg", orAll, 0);
    orAll = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) orAll |= matA[i][j] | matB[i][j];
    checkOutput("rst_matrices", orAll, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", inReady, 1);
    checkOutput("idle_mm_reset", mmReset, 0);

    for (int v = 0; v < 9; v++) applyStimulus(vecs[v], $sformatf("vec%0d", v));

    readyMode = 1;
    applyStimulus(vecs[9], "stall_2x3x2");
    readyMode = 0;

    pv = '0;
    pv.words[0] = 32'd1; pv.words[1] = 32'd1; pv.words[2] = 32'd1;
    pv.words[3] = 32'd9; pv.words[4] = 32'd15; pv.words[5] = 32'd2;
    for (int j = 0; j < DIM; j++) begin
      pv.words[6 + j] = 32'(j + 1);
      pv.exp[j]       = 32'(2 * (j + 1));
    end
    pv.nw = 21;
    pv.ne = 15;
    applyStimulus(pv, "wide_p15");

    @(posedge clk);
    #1;
    gotData.delete();
    gotLast.delete();
    for (int i = 0; i < 8; i++) sendWord(vecs[0].words[i]);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_in_ready", inReady, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_mm_reset", mmReset, 1);
    checkOutput("abort_op1", operationReg[1], 0);
    checkOutput("abort_a01", matA[0][1], 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_output", gotData.size(), 0);
    applyStimulus(vecs[0], "after_abort");

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
